// File: rtl/thirtytwobit_demux_one_two_reg.sv
// 1-to-2 demultiplexer with a one-entry registered holding slot per output port.
// Optional per-port output transfer counters are enabled with DEMUX_COUNT_EN.
module thirtytwobit_demux_one_two_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        sel,
    output logic        in_ready,
    output logic [31:0] out0_data,
    output logic        out0_valid,
    input  logic        out0_ready,
    output logic [31:0] out1_data,
    output logic        out1_valid,
    input  logic        out1_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [7:0]  cnt0,
    output logic [7:0]  cnt1
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t st0, st0_nxt;
    slot_state_t st1, st1_nxt;
    logic        in_hs;
    logic        ld0, ld1;
    logic        hs0, hs1;

    always_comb begin
        out0_valid = (st0 == FULL);
        out1_valid = (st1 == FULL);
        // A slot can accept when empty or when it drains in this same cycle.
        in_ready   = sel ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready);
        in_hs      = in_valid && in_ready;
        ld0        = in_hs && !sel;
        ld1        = in_hs && sel;
        hs0        = out0_valid && out0_ready;
        hs1        = out1_valid && out1_ready;

        st0_nxt = st0;
        if (ld0)
            st0_nxt = FULL;
        else if (hs0)
            st0_nxt = EMPTY;

        st1_nxt = st1;
        if (ld1)
            st1_nxt = FULL;
        else if (hs1)
            st1_nxt = EMPTY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st0 <= EMPTY;
            st1 <= EMPTY;
        end else begin
            st0 <= st0_nxt;
            st1 <= st1_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out0_data <= '0;
            out1_data <= '0;
        end else begin
            if (ld0)
                out0_data <= in_data;
            if (ld1)
                out1_data <= in_data;
        end
    end

`ifdef DEMUX_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (hs0)
                cnt0 <= cnt0 + 8'd1;
            if (hs1)
                cnt1 <= cnt1 + 8'd1;
        end
    end
`endif

endmodule

// File: doc/thirtytwobit_demux_one_two_reg.md
THIRTYTWOBIT_DEMUX_ONE_TWO_REG -- requirements
Module: thirtytwobit_demux_one_two_reg

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_data  input  32  word to be steered.
REQ-005 in_valid  input  1  in_data/sel valid this cycle.
REQ-006 sel  input  1  destination: 0 -> port 0, 1 -> port 1; sampled with in_data.
REQ-007 in_ready  output  1  block accepts the input word this cycle.
REQ-008 out0_data, out1_data  output  32 each  registered output words.
REQ-009 out0_valid, out1_valid  output  1 each  output register holds a word.
REQ-010 out0_ready, out1_ready  input  1 each  downstream accepts the word this cycle.
REQ-011 cnt0, cnt1  output  8 each  per-port transfer counts; present only with DEMUX_COUNT_EN.

Function
REQ-012 Each port SHALL own a one-entry holding register with two states: EMPTY (outN_valid=0) and FULL (outN_valid=1).
REQ-013 An input handshake SHALL occur in a cycle when in_valid=1 and in_ready=1; an output handshake on port N SHALL occur when outN_valid=1 and outN_ready=1.
REQ-014 in_ready SHALL be combinational: if sel=0, in_ready = !out0_valid || out0_ready; if sel=1, in_ready = !out1_valid || out1_ready; in_ready is independent of in_valid.
REQ-015 On an input handshake, the selected port's register SHALL load in_data at the next edge and its state SHALL become FULL; latency from acceptance to outN_valid=1 is exactly 1 cycle.
REQ-016 Port N transitions: EMPTY->FULL on input handshake to N; FULL->EMPTY on output handshake on N with no input handshake to N; FULL->FULL with new data on simultaneous output handshake and input handshake to N (back-to-back, full throughput).
REQ-017 The non-selected port SHALL be unaffected by the input; its data and valid hold unless it completes its own output handshake.
REQ-018 outN_data SHALL remain stable while outN_valid=1 and outN_ready=0.
REQ-019 A FULL port with outN_ready=0 SHALL stall only inputs with sel=N; inputs with the other sel proceed.
REQ-020 in_data SHALL NOT be captured and no state SHALL change when in_valid=0.
REQ-021 Both ports MAY drain in the same cycle; there is no ordering guarantee between ports.

Reset
REQ-022 While reset=1, out0_valid=out1_valid=0, out0_data=out1_data=32'h0000_0000, cnt0=cnt1=8'h00, asynchronously.
REQ-023 Reset asserted mid-transfer SHALL discard held words with no output handshake; the first edge after deassertion sees both ports EMPTY, so in_ready=1.

Configuration
REQ-024 With macro DEMUX_COUNT_EN defined, cnt0/cnt1 ports and counters SHALL exist; cntN increments by 1 on each output handshake on port N, wrapping 8'hFF -> 8'h00.
REQ-025 Without DEMUX_COUNT_EN, cnt0/cnt1 SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-026 Reset, then in_valid=1, sel=0, in_data=32'hDEAD_BEEF, out0_ready=1 -> next cycle out0_valid=1, out0_data=32'hDEAD_BEEF, out1_valid=0.
REQ-027 out1_ready=0, send 32'h1111_1111 (sel=1), then 32'h2222_2222 (sel=1) -> second word sees in_ready=0, out1_data holds 32'h1111_1111; raise out1_ready -> 32'h2222_2222 appears the following cycle.
REQ-028 Port 1 FULL and stalled, send 32'h3333_3333 with sel=0 -> in_ready=1, out0_data=32'h3333_3333 next cycle, port 1 unchanged.
REQ-029 Both readies 1, stream 8 words with sel toggling 0,1,0,1... -> in_ready=1 every cycle, each word on its port exactly 1 cycle later.
REQ-030 Port 0 FULL with 32'hCAFE_0000, assert reset for one cycle mid-stall -> both valids 0, data 0; after deassertion in_ready=1.
REQ-031 With DEMUX_COUNT_EN, 257 output handshakes on port 0 -> cnt0=8'h01, cnt1=8'h00.
